mem_port_arbiter: RTL and testbench

Shares the single byte-addressed, big-endian data/instruction RAM port between two requesters: the instruction-fetch stage (read-only) and the MEM stage (read/write). Grants one requester per cycle with data priority and an anti-starvation limit. Registers the read data and response flags for each requester, and produces per-requester stall signals for the hazard unit. Sits between the pipeline stages and the RAM instance.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_port_arbiter_starve_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the instruction/data RAM port arbiter.
//   grant_t    - which requester owns the RAM port this cycle
//   WORD_BYTES - bytes per RAM word (32-bit words, byte addressed)
//   is_aligned - true when the low address bits select a word boundary
package mem_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    localparam int WORD_BYTES = 4;

    // Only the two byte-select bits matter for word alignment.
    function automatic logic is_aligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & 2'(WORD_BYTES - 1)) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// starve_counter: 4-bit saturating counter with synchronous clear.
//   clk, rst     - clock, asynchronous active-high reset
//   i_inc        - count one more data win while a fetch waits
//   i_clr        - fetch granted or fetch no longer requesting
//   o_at_limit   - counter has reached LIMIT (fetch must win next contention)
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    input  logic       i_clr,
    output logic       o_at_limit
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && (r_cnt < 4'(LIMIT))) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_at_limit = (r_cnt == 4'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-addressed big-endian RAM port between
// instruction fetch (read-only) and the MEM stage (read/write).
//   clk, rst                  - clock, asynchronous active-high reset
//   if_req/if_addr            - fetch request
//   if_rdata/if_valid/if_err  - registered fetch response (1-cycle latency)
//   if_stall                  - fetch request not served this cycle
//   d_req/d_we/d_addr/d_wdata - data request (load or store)
//   d_rdata/d_valid/d_err     - registered data response (1-cycle latency)
//   d_stall                   - data request not served this cycle
//   ram_*                     - combinational RAM port drive / read data
//
// Handshake: a request is accepted in any cycle its stall is low; the
// response (valid, plus err for misaligned) appears exactly one cycle later.
// While stall is high the requester holds req/addr/we/wdata stable. A new
// request may be presented in the same cycle as the previous valid.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    output logic                  if_err,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  d_err,
    output logic                  d_stall,
    output logic                  ram_mem_write,
    output logic                  ram_mem_read,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    logic   w_if_ok;
    logic   w_d_ok;
    logic   w_if_mis;
    logic   w_d_mis;
    logic   w_at_limit;
    grant_t w_grant;

    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_if_valid;
    logic                  r_if_err;
    logic                  r_d_valid;
    logic                  r_d_err;

    // Misaligned requests never reach the RAM; they are answered with err.
    assign w_if_ok  = if_req &&  is_aligned(if_addr[1:0]);
    assign w_d_ok   = d_req  &&  is_aligned(d_addr[1:0]);
    assign w_if_mis = if_req && !is_aligned(if_addr[1:0]);
    assign w_d_mis  = d_req  && !is_aligned(d_addr[1:0]);

    // Data wins contention unless the fetch has already lost STARVE_LIMIT times.
    always_comb begin
        w_grant = GNT_NONE;
        if (w_if_ok && w_d_ok) begin
            w_grant = w_at_limit ? GNT_IF : GNT_D;
        end else if (w_d_ok) begin
            w_grant = GNT_D;
        end else if (w_if_ok) begin
            w_grant = GNT_IF;
        end
    end

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_if_ok && (w_grant == GNT_D)),
        .i_clr      ((w_grant == GNT_IF) || !if_req),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        ram_mem_write  = 1'b0;
        ram_mem_read   = 1'b0;
        ram_addr       = '0;
        ram_write_data = '0;
        case (w_grant)
            GNT_IF: begin
                ram_addr     = if_addr;
                ram_mem_read = 1'b1;
            end
            GNT_D: begin
                ram_addr       = d_addr;
                ram_mem_write  = d_we;
                ram_mem_read   = !d_we;
                ram_write_data = d_wdata;
            end
            default: ;
        endcase
    end

    // Misaligned requests are "served" (by an error) in their own cycle.
    assign if_stall = w_if_ok && (w_grant != GNT_IF);
    assign d_stall  = w_d_ok  && (w_grant != GNT_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_if_err   <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
        end else begin
            r_if_valid <= (w_grant == GNT_IF) || w_if_mis;
            r_if_err   <= w_if_mis;
            r_d_valid  <= (w_grant == GNT_D) || w_d_mis;
            r_d_err    <= w_d_mis;
            if (w_grant == GNT_IF) begin
                r_if_rdata <= ram_read_data;
            end
            // Store acks leave d_rdata untouched.
            if ((w_grant == GNT_D) && !d_we) begin
                r_d_rdata <= ram_read_data;
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign if_valid = r_if_valid;
    assign if_err   = r_if_err;
    assign d_rdata  = r_d_rdata;
    assign d_valid  = r_d_valid;
    assign d_err    = r_d_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid, if_err, if_stall;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid, d_err, d_stall;
    logic          ram_mem_write, ram_mem_read;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_write_data;
    logic [DW-1:0] ram_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected responses: {err, data}
    logic [DW:0] exp_if_q[$];
    logic [DW:0] exp_d_q[$];

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_valid       (if_valid),
        .if_err         (if_err),
        .if_stall       (if_stall),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_valid        (d_valid),
        .d_err          (d_err),
        .d_stall        (d_stall),
        .ram_mem_write  (ram_mem_write),
        .ram_mem_read   (ram_mem_read),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model (big-endian, byte addressed) ----------------
    logic [7:0] ram_mem [0:1023];

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = {a[AW-1:2], 2'b00};
        return {ram_mem[b], ram_mem[b + 1], ram_mem[b + 2], ram_mem[b + 3]};
    endfunction

    assign ram_read_data = ram_word(ram_addr);

    always @(posedge clk) begin
        if (ram_mem_write) begin
            ram_mem[{ram_addr[AW-1:2], 2'b00}]         <= ram_write_data[31:24];
            ram_mem[{ram_addr[AW-1:2], 2'b00} + 10'd1] <= ram_write_data[23:16];
            ram_mem[{ram_addr[AW-1:2], 2'b00} + 10'd2] <= ram_write_data[15:8];
            ram_mem[{ram_addr[AW-1:2], 2'b00} + 10'd3] <= ram_write_data[7:0];
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (if_valid) begin
                if (exp_if_q.size() == 0) begin
                    check("if_unexpected_valid", {1'b0, 32'd1}, {1'b0, 32'd0});
                end else begin
                    check("if_response", {if_err, if_rdata}, exp_if_q.pop_front());
                end
            end
            if (d_valid) begin
                if (exp_d_q.size() == 0) begin
                    check("d_unexpected_valid", {1'b0, 32'd1}, {1'b0, 32'd0});
                end else begin
                    check("d_response", {d_err, d_rdata}, exp_d_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dwe,
                         input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    // One cycle with inputs already driven; stalls checked mid-cycle.
    task automatic cycle(input string name, input logic exp_if_stall, input logic exp_d_stall);
        @(negedge clk);
        check({name, "_if_stall"}, {32'd0, if_stall}, {32'd0, exp_if_stall});
        check({name, "_d_stall"},  {32'd0, d_stall},  {32'd0, exp_d_stall});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = 8'h00;
        ram_mem[16] = 8'hDE; ram_mem[17] = 8'hAD; ram_mem[18] = 8'hBE; ram_mem[19] = 8'hEF;

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_if_rdata", {1'b0, if_rdata}, 33'd0);
        check("rst_d_rdata",  {1'b0, d_rdata},  33'd0);
        check("rst_valids",   {29'd0, if_valid, if_err, d_valid, d_err}, 33'd0);
        check("rst_ram_ctl",  {31'd0, ram_mem_write, ram_mem_read}, 33'd0);
        rst = 1'b0;
        idle(1);

        // Fetch alone at 0x010
        drive(1'b1, 10'h010, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("fetch_ram_read", {32'd0, ram_mem_read}, 33'd1);
        check("fetch_ram_addr", {23'd0, ram_addr}, {23'd0, 10'h010});
        @(posedge clk); #1;
        exp_if_q.push_back({1'b0, 32'hDEADBEEF});
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        cycle("after_fetch", 1'b0, 1'b0);

        // Store then load 0x020
        drive(1'b0, '0, 1'b1, 1'b1, 10'h020, 32'h12345678);
        exp_d_q.push_back({1'b0, 32'h0});
        cycle("store", 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 10'h020, '0);
        exp_d_q.push_back({1'b0, 32'h12345678});
        cycle("load", 1'b0, 1'b0);
        idle(2);

        // Contention: 4 data wins then a forced fetch, twice
        drive(1'b1, 10'h010, 1'b1, 1'b0, 10'h020, '0);
        for (int i = 0; i < 10; i++) begin
            if ((i % 5) == 4) begin
                exp_if_q.push_back({1'b0, 32'hDEADBEEF});
                cycle("contend_fetch_turn", 1'b0, 1'b1);
            end else begin
                exp_d_q.push_back({1'b0, 32'h12345678});
                cycle("contend_data_turn", 1'b1, 1'b0);
            end
        end
        idle(2);

        // Misaligned store to 0x021 with concurrent fetch
        drive(1'b1, 10'h010, 1'b1, 1'b1, 10'h021, 32'hFFFFFFFF);
        exp_if_q.push_back({1'b0, 32'hDEADBEEF});
        exp_d_q.push_back({1'b1, 32'h12345678});
        @(negedge clk);
        check("mis_store_no_write", {32'd0, ram_mem_write}, 33'd0);
        check("mis_store_stalls", {31'd0, if_stall, d_stall}, 33'd0);
        @(posedge clk); #1;
        idle(2);

        // Same-word race at 0x040
        drive(1'b1, 10'h040, 1'b1, 1'b1, 10'h040, 32'hCAFEF00D);
        exp_d_q.push_back({1'b0, 32'h12345678});
        cycle("race_store", 1'b1, 1'b0);
        drive(1'b1, 10'h040, 1'b0, 1'b0, '0, '0);
        exp_if_q.push_back({1'b0, 32'hCAFEF00D});
        cycle("race_fetch", 1'b0, 1'b0);
        idle(2);

        // Misaligned fetch alone
        drive(1'b1, 10'h012, 1'b0, 1'b0, '0, '0);
        exp_if_q.push_back({1'b1, 32'hCAFEF00D});
        @(negedge clk);
        check("mis_fetch_no_read", {32'd0, ram_mem_read}, 33'd0);
        @(posedge clk); #1;
        idle(2);

        // Fetch stalled then dropped: no fetch response
        drive(1'b1, 10'h010, 1'b1, 1'b0, 10'h040, '0);
        exp_d_q.push_back({1'b0, 32'hCAFEF00D});
        cycle("drop_contend", 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("drop_no_access", {31'd0, ram_mem_read, ram_mem_write}, 33'd0);
        @(posedge clk); #1;
        idle(2);

        // Reset while a load response is in flight
        drive(1'b0, '0, 1'b1, 1'b0, 10'h020, '0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        #1;
        check("midrst_d_valid", {32'd0, d_valid}, 33'd0);
        check("midrst_d_rdata", {1'b0, d_rdata}, 33'd0);
        check("midrst_if_rdata", {1'b0, if_rdata}, 33'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        // Final memory contents and drained scoreboard
        check("mem_020", {1'b0, ram_word(10'h020)}, {1'b0, 32'h12345678});
        check("mem_040", {1'b0, ram_word(10'h040)}, {1'b0, 32'hCAFEF00D});
        check("if_q_drained", 33'(exp_if_q.size()), 33'd0);
        check("d_q_drained",  33'(exp_d_q.size()),  33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
